score_frame_collector: RTL and testbench

- Sits between the output-layer neuron stream and the argmax stage `predict_digit`, on its upstream side.
- Accepts ten class scores serially on a valid/ready stream, ordered digit 0 to digit 9.
- Packs the scores into the 10-slot bus expected by the argmax stage, pulses its start, waits for its done, then holds the predicted digit on a valid/ready result port until the consumer takes it.

---
 rtl/score_frame_collector.sv | 130 +++++++++++++
 tb/tb_score_frame_collector.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_frame_collector.sv
// Score frame collector: gathers ten serial class scores, packs them for the
// argmax stage, launches it, waits for its result and presents the digit.
module score_frame_collector #(
    parameter int unsigned WIDTH         = 40,
    parameter int unsigned SIGNED_SCORES = 1,
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              score_valid,
    output logic              score_ready,
    input  logic [WIDTH-1:0]  score_data,
    input  logic              score_last,
    output logic [10*WIDTH-1:0] nums_out,
    output logic              start_out,
    input  logic              pred_done,
    input  logic [3:0]        pred_digit,
    output logic              digit_valid,
    input  logic              digit_ready,
    output logic [3:0]        digit_out,
    output logic              frame_err
);

    localparam int unsigned TmoW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StCollect, StLaunch, StWait, StPresent} state_e;

    state_e              state_q, state_d;
    logic [3:0]          count_q, count_d;
    logic [TmoW-1:0]     tmo_q, tmo_d;
    logic [10*WIDTH-1:0] nums_q, nums_d;
    logic [3:0]          digit_q, digit_d;
    logic                err_q, err_d;
    logic [WIDTH-1:0]    beat_val;

    // Offset-binary conversion so the unsigned argmax orders signed scores
    always_comb begin
        beat_val = score_data;
        if (SIGNED_SCORES != 0) begin
            beat_val[WIDTH-1] = ~score_data[WIDTH-1];
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        tmo_d       = tmo_q;
        nums_d      = nums_q;
        digit_d     = digit_q;
        err_d       = 1'b0;
        score_ready = 1'b0;
        start_out   = 1'b0;
        digit_valid = 1'b0;
        case (state_q)
            StCollect: begin
                score_ready = 1'b1;
                if (score_valid) begin
                    // Digit k lands in slot 9-k; argmax reports 9 minus winning slot
                    for (int s = 0; s < 10; s++) begin
                        if (count_q == 4'(9 - s)) begin
                            nums_d[s*WIDTH +: WIDTH] = beat_val;
                        end
                    end
                    if (count_q == 4'd9) begin
                        count_d = 4'd0;
                        if (score_last) begin
                            state_d = StLaunch;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (score_last) begin
                        count_d = 4'd0;
                        err_d   = 1'b1;
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end
            end
            StLaunch: begin
                start_out = 1'b1;
                tmo_d     = '0;
                state_d   = StWait;
            end
            StWait: begin
                tmo_d = tmo_q + 1'b1;
                if (pred_done) begin
                    digit_d = pred_digit;
                    state_d = StPresent;
                end else if (tmo_q == TmoW'(TIMEOUT - 2)) begin
                    // Counter about to reach TIMEOUT-1: abort so the error
                    // pulse lands TIMEOUT cycles after start_out
                    err_d   = 1'b1;
                    state_d = StCollect;
                end
            end
            StPresent: begin
                digit_valid = 1'b1;
                if (digit_ready) begin
                    state_d = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StCollect;
            count_q <= 4'd0;
            tmo_q   <= '0;
            nums_q  <= '0;
            digit_q <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tmo_q   <= tmo_d;
            nums_q  <= nums_d;
            digit_q <= digit_d;
            err_q   <= err_d;
        end
    end

    assign nums_out  = nums_q;
    assign digit_out = digit_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_score_frame_collector.sv
// Directed bench for score_frame_collector: instance 0 signed, instance 1 unsigned,
// each driven against a 5-cycle argmax stand-in.
module tb_score_frame_collector;

    logic        clk;
    logic        reset;
    logic        score_valid [2];
    logic        score_ready [2];
    logic [39:0] score_data  [2];
    logic        score_last  [2];
    logic [399:0] nums       [2];
    logic        start       [2];
    logic        pred_done   [2];
    logic [3:0]  pred_digit  [2];
    logic        digit_valid [2];
    logic        dr          [2];
    logic [3:0]  digit_out   [2];
    logic        frame_err   [2];
    logic        stub_en     [2];
    logic        manual_pd   [2];

    logic [39:0] frame_sc [10];
    int checks;
    int errors;
    int err_seen;
    int start_seen;
    int base;
    bit early;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [2:0]  cnt;
        logic        busy;
        logic        stub_pd;
        logic [39:0] best_v;
        int          best_s;

        score_frame_collector #(
            .WIDTH(40),
            .SIGNED_SCORES((g == 0) ? 1 : 0),
            .TIMEOUT(64)
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .score_valid(score_valid[g]),
            .score_ready(score_ready[g]),
            .score_data(score_data[g]),
            .score_last(score_last[g]),
            .nums_out(nums[g]),
            .start_out(start[g]),
            .pred_done(pred_done[g]),
            .pred_digit(pred_digit[g]),
            .digit_valid(digit_valid[g]),
            .digit_ready(dr[g]),
            .digit_out(digit_out[g]),
            .frame_err(frame_err[g])
        );

        // Argmax stand-in: done pulse 5 cycles after start
        always @(posedge clk) begin
            if (reset) begin
                busy    <= 1'b0;
                cnt     <= 3'd0;
                stub_pd <= 1'b0;
            end else begin
                stub_pd <= 1'b0;
                if (start[g] && stub_en[g]) begin
                    busy <= 1'b1;
                    cnt  <= 3'd4;
                end else if (busy) begin
                    if (cnt == 3'd1) begin
                        stub_pd <= 1'b1;
                        busy    <= 1'b0;
                    end
                    cnt <= cnt - 3'd1;
                end
            end
        end

        always_comb begin
            best_s = 0;
            best_v = nums[g][39:0];
            for (int s = 1; s < 10; s++) begin
                if (nums[g][s*40 +: 40] > best_v) begin
                    best_v = nums[g][s*40 +: 40];
                    best_s = s;
                end
            end
        end

        assign pred_digit[g] = 4'(9 - best_s);
        assign pred_done[g]  = stub_pd | manual_pd[g];
    end

    always @(negedge clk) begin
        if (frame_err[0]) err_seen++;
        if (start[0]) start_seen++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [39:0] val);
        for (int k = 0; k < 10; k++) frame_sc[k] = val;
    endtask

    // Sends n beats of frame_sc; score_last on the final beat when with_last
    task automatic send_beats(input int g, input int n, input bit with_last);
        for (int k = 0; k < n; k++) begin
            int guard = 0;
            score_valid[g] = 1'b1;
            score_data[g]  = frame_sc[k];
            score_last[g]  = with_last && (k == n - 1);
            @(negedge clk);
            while (!score_ready[g] && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) check_eq("beat_accept", 0, 1);
            @(posedge clk);
            #1;
        end
        score_valid[g] = 1'b0;
        score_last[g]  = 1'b0;
    endtask

    task automatic wait_digit(input int g, input logic [3:0] exp, input string tag);
        int guard = 0;
        while (!digit_valid[g] && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_eq({tag, "_valid"}, 64'(digit_valid[g]), 1);
        check_eq({tag, "_digit"}, 64'(digit_out[g]), 64'(exp));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        err_seen = 0;
        start_seen = 0;
        reset = 1'b1;
        for (int g = 0; g < 2; g++) begin
            score_valid[g] = 1'b0;
            score_data[g]  = '0;
            score_last[g]  = 1'b0;
            dr[g]          = 1'b1;
            stub_en[g]     = 1'b1;
            manual_pd[g]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 64'(score_ready[0]), 1);
        check_eq("rst_outs", {start[0], digit_valid[0], frame_err[0], digit_out[0]}, 0);
        check_eq("rst_nums", 64'(nums[0][63:0] | nums[0][399:336]), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic frame, latency start_out -> digit_valid
        for (int k = 0; k < 10; k++) frame_sc[k] = 40'(10 * (k + 1));
        frame_sc[7] = 40'd500;
        base = start_seen;
        send_beats(0, 10, 1);
        check_eq("basic_start", 64'(start[0]), 1);
        check_eq("basic_ready_lo", 64'(score_ready[0]), 0);
        early = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            if (i < 6 && digit_valid[0]) early = 1'b1;
        end
        check_eq("basic_early", 64'(early), 0);
        check_eq("basic_valid6", 64'(digit_valid[0]), 1);
        check_eq("basic_digit", 64'(digit_out[0]), 7);
        @(posedge clk);
        #1;
        check_eq("basic_after", {digit_valid[0], score_ready[0]}, 2'b01);
        check_eq("basic_starts", 64'(start_seen - base), 1);

        // Signed ordering
        fill('0 - 40'd1000);
        frame_sc[2] = '0 - 40'd3;
        send_beats(0, 10, 1);
        check_eq("signed_slot", nums[0][7*40 +: 40], frame_sc[2] ^ {1'b1, 39'b0});
        wait_digit(0, 4'd2, "signed_neg");
        fill('0 - 40'd7);
        frame_sc[3] = 40'd7;
        send_beats(0, 10, 1);
        wait_digit(0, 4'd3, "signed_mix");

        // Unsigned instance: top-bit value must stay largest
        for (int k = 0; k < 10; k++) frame_sc[k] = 40'(3 * k + 1);
        frame_sc[9] = 40'h80_0000_0000;
        send_beats(1, 10, 1);
        check_eq("unsigned_slot0", nums[1][39:0], 40'h80_0000_0000);
        wait_digit(1, 4'd9, "unsigned");

        // Framing errors: early last, then missing last
        for (int k = 0; k < 10; k++) frame_sc[k] = 40'(k + 1);
        base = start_seen;
        send_beats(0, 4, 1);
        check_eq("ferr_pulse", 64'(frame_err[0]), 1);
        check_eq("ferr_ready", 64'(score_ready[0]), 1);
        @(posedge clk);
        #1;
        check_eq("ferr_drop", 64'(frame_err[0]), 0);
        send_beats(0, 10, 0);
        check_eq("ferr_nolast", 64'(frame_err[0]), 1);
        check_eq("ferr_nostart", 64'(start_seen - base), 0);
        fill(40'd5);
        frame_sc[0] = 40'd900;
        send_beats(0, 10, 1);
        wait_digit(0, 4'd0, "ferr_clean");

        // Backpressure
        @(posedge clk);
        #1;
        dr[0] = 1'b0;
        fill(40'd1);
        frame_sc[5] = 40'd77;
        send_beats(0, 10, 1);
        wait_digit(0, 4'd5, "bp");
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_hold", {digit_valid[0], score_ready[0], digit_out[0]}, {2'b10, 4'd5});
        end
        dr[0] = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_release", {digit_valid[0], score_ready[0]}, 2'b01);

        // Timeout with the argmax stand-in silenced
        stub_en[0] = 1'b0;
        send_beats(0, 10, 1);
        check_eq("tmo_start", 64'(start[0]), 1);
        early = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk);
            #1;
            if (i < 64 && frame_err[0]) early = 1'b1;
        end
        check_eq("tmo_early", 64'(early), 0);
        check_eq("tmo_err", 64'(frame_err[0]), 1);
        check_eq("tmo_ready", 64'(score_ready[0]), 1);
        manual_pd[0] = 1'b1;
        @(posedge clk);
        #1;
        manual_pd[0] = 1'b0;
        check_eq("tmo_err_drop", 64'(frame_err[0]), 0);
        early = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (digit_valid[0]) early = 1'b1;
        end
        check_eq("tmo_late_done", 64'(early), 0);
        stub_en[0] = 1'b1;

        // Reset mid-frame
        for (int k = 0; k < 10; k++) frame_sc[k] = 40'(k + 100);
        send_beats(0, 5, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_outs", {start[0], digit_valid[0], frame_err[0], score_ready[0]}, 4'b0001);
        check_eq("mid_rst_nums", 64'(nums[0][399:360] | nums[0][39:0]), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        manual_pd[0] = 1'b1;
        @(posedge clk);
        #1;
        manual_pd[0] = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_pd", {digit_valid[0], score_ready[0]}, 2'b01);
        base = err_seen;
        fill(40'd20);
        frame_sc[4] = 40'd400;
        send_beats(0, 10, 1);
        wait_digit(0, 4'd4, "mid_rst");
        check_eq("mid_rst_noerr", 64'(err_seen - base), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
